// File: rtl/number_display_pkg.sv
// Shared types and constants for the score digit renderer: glyph geometry,
// BCD nibble type, converter state encoding and the 16-entry glyph ROM.
// The ROM is generated at elaboration from a seven-segment description so
// every glyph shares stroke geometry. Codes 10-15 render blank.
package number_display_pkg;

   localparam int GLYPH_W = 16;
   localparam int GLYPH_H = 32;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } conv_state_t;

   // Row word bit 15 (index 0 of the ascending range) is the leftmost column.
   typedef bit [0:31][0:15]        glyph_t;
   typedef bit [0:15][0:31][0:15]  glyph_rom_t;

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Segment bits: [6]=a top, [5]=b upper right, [4]=c lower right,
   // [3]=d bottom, [2]=e lower left, [1]=f upper left, [0]=g middle.
   // '1' is drawn as a centred bar so it sits visually centred in its cell.
   function automatic glyph_t make_glyph(input int code);
      glyph_t     g;
      logic [6:0] seg;
      logic       lit;
      g = '0;
      case (code)
         0:       seg = 7'b1111110;
         2:       seg = 7'b1101101;
         3:       seg = 7'b1111001;
         4:       seg = 7'b0110011;
         5:       seg = 7'b1011011;
         6:       seg = 7'b1011111;
         7:       seg = 7'b1110000;
         8:       seg = 7'b1111111;
         9:       seg = 7'b1111011;
         default: seg = 7'b0000000;
      endcase
      for (int r = 0; r < 32; r++) begin
         for (int c = 0; c < 16; c++) begin
            lit = (seg[6] && r <= 3  && c >= 2 && c <= 13)
               || (seg[5] && r >= 2  && r <= 15 && c >= 12)
               || (seg[4] && r >= 16 && r <= 29 && c >= 12)
               || (seg[3] && r >= 28 && c >= 2  && c <= 13)
               || (seg[2] && r >= 16 && r <= 29 && c <= 3)
               || (seg[1] && r >= 2  && r <= 15 && c <= 3)
               || (seg[0] && r >= 14 && r <= 17 && c >= 2 && c <= 13);
            if (code == 1) lit = (c >= 6 && c <= 9);
            g[r][c] = lit;
         end
      end
      return g;
   endfunction

   function automatic glyph_rom_t build_rom();
      glyph_rom_t rom;
      for (int k = 0; k < 16; k++) rom[k] = make_glyph(k);
      return rom;
   endfunction

   localparam glyph_rom_t GLYPH_ROM = build_rom();

endpackage

// File: rtl/score_digits_bitmap_if.sv
// Load handshake between a score source and the digit renderer:
// the source presents value with a single-cycle load; busy reports that a
// conversion is running and further loads are being ignored.
interface score_digits_bitmap_if #(
   parameter int VALUE_W = 14
);
   logic [VALUE_W-1:0] value;
   logic               load;
   logic               busy;

   modport master (output value, output load, input busy);
   modport slave  (input value, input load, output busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// Input is saturated to 10^DIGITS-1 on capture; the finished BCD word is
// announced by a one-cycle bcd_valid pulse in COMMIT.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for load; the only state in which load is accepted
// ST_SHIFT  | add-3 adjust then shift {bcd,bin}; down-counter runs VALUE_W
// ST_COMMIT | scratch BCD is final; bcd_valid pulses for one cycle
module bin2bcd_seq
   import number_display_pkg::*;
#(
   parameter int DIGITS  = 4,
   parameter int VALUE_W = 14
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic [VALUE_W-1:0]    value,
   input  logic                  load,
   output logic                  busy,
   output logic                  bcd_valid,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam longint unsigned SAT_VAL = pow10(DIGITS) - 1;
   localparam int SAT_W = $clog2(SAT_VAL + 1);
   localparam int CMP_W = (VALUE_W > SAT_W) ? VALUE_W : SAT_W;
   localparam int CNT_W = $clog2(VALUE_W + 1);

   conv_state_t          state, state_next;
   logic [VALUE_W-1:0]   bin;
   logic [VALUE_W-1:0]   value_sat;
   logic [4*DIGITS-1:0]  bcd_adj;
   logic [CNT_W-1:0]     cnt;
   logic                 over;

   // Compare in a width that holds both operands. When VALUE_W is too narrow
   // to exceed the limit, over is never set, so the truncating cast is unused.
   assign over      = CMP_W'(value) > CMP_W'(SAT_VAL);
   assign value_sat = over ? VALUE_W'(SAT_VAL) : value;

   // state register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= ST_IDLE;
      else         state <= state_next;
   end

   // next state and status decode
   always_comb begin
      state_next = state;
      busy       = 1'b1;
      bcd_valid  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (load) state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (cnt == CNT_W'(1)) state_next = ST_COMMIT;
         end
         ST_COMMIT: begin
            bcd_valid  = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // add-3 correction of every nibble that would overflow past 9 on shift
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // capture on accepted load, then shift one binary bit per cycle
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         bin <= '0;
         bcd <= '0;
         cnt <= '0;
      end else if (state == ST_IDLE) begin
         if (load) begin
            bin <= value_sat;
            bcd <= '0;
            cnt <= CNT_W'(VALUE_W);
         end
      end else if (state == ST_SHIFT) begin
         {bcd, bin} <= {bcd_adj, bin} << 1;
         cnt        <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/score_digits_bitmap.sv
// Multi-digit decimal score bitmap for the VGA object pipeline.
// Holds the displayed digit bank (updated atomically from the converter),
// and performs the registered per-pixel glyph lookup.
// Optional build macro SCORE_DIGITS_LZB_EN: leading-zero blanking, with the
// blank mask computed from the finished BCD and registered with the bank.
module score_digits_bitmap
   import number_display_pkg::*;
#(
   parameter int         DIGITS      = 4,
   parameter int         VALUE_W     = 14,
   parameter logic [7:0] DIGIT_COLOR = 8'hFF
) (
   input  logic                 clk,
   input  logic                 resetN,
   score_digits_bitmap_if.slave ctl,
   input  logic [10:0]          offsetX,
   input  logic [10:0]          offsetY,
   input  logic                 InsideRectangle,
   output logic                 drawingRequest,
   output logic [7:0]           RGBout
);

   logic                 bcd_valid;
   logic [4*DIGITS-1:0]  bcd;
   bcd_t                 digit_bank [DIGITS];
   logic [DIGITS-1:0]    blank;

   bin2bcd_seq #(
      .DIGITS  (DIGITS),
      .VALUE_W (VALUE_W)
   ) u_conv (
      .clk       (clk),
      .resetN    (resetN),
      .value     (ctl.value),
      .load      (ctl.load),
      .busy      (ctl.busy),
      .bcd_valid (bcd_valid),
      .bcd       (bcd)
   );

   // commit all digits at once; digit 0 (leftmost) is the top nibble
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < DIGITS; i++) digit_bank[i] <= '0;
      end else if (bcd_valid) begin
         for (int i = 0; i < DIGITS; i++) digit_bank[i] <= bcd[4*(DIGITS-1-i) +: 4];
      end
   end

`ifdef SCORE_DIGITS_LZB_EN
   logic [DIGITS-1:0] blank_next;
   logic              lead;

   // leading zeros are blanked; the last digit is always shown
   always_comb begin
      blank_next = '0;
      lead       = 1'b1;
      for (int i = 0; i < DIGITS-1; i++) begin
         lead          = lead & (bcd[4*(DIGITS-1-i) +: 4] == 4'd0);
         blank_next[i] = lead;
      end
   end

   // mask registered together with the bank; reset shows a single "0"
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)        blank <= {1'b0, {(DIGITS-1){1'b1}}};
      else if (bcd_valid) blank <= blank_next;
   end
`else
   assign blank = '0;
`endif

   logic [6:0] idx;
   logic [3:0] col;
   logic [4:0] row;
   logic       in_area;
   logic       hide;
   logic       lit;
   bcd_t       code;

   assign idx     = offsetX[10:4];
   assign col     = offsetX[3:0];
   assign row     = offsetY[4:0];
   assign in_area = InsideRectangle
                 && (offsetX < 11'(GLYPH_W * DIGITS))
                 && (offsetY < 11'(GLYPH_H));

   // select the digit cell under the current pixel
   always_comb begin
      code = '0;
      hide = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == 7'(i)) begin
            code = digit_bank[i];
            hide = blank[i];
         end
      end
   end

   assign lit = in_area && !hide && GLYPH_ROM[code][row][col];

   // one-cycle registered pixel decision
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) drawingRequest <= 1'b0;
      else         drawingRequest <= lit;
   end

   assign RGBout = DIGIT_COLOR;

endmodule

// File: doc/score_digits_bitmap.md
# score_digits_bitmap

Renders an unsigned binary value as a row of `DIGITS` decimal glyphs (16×32 pixels each) inside the VGA object pipeline. It is the multi-digit, parametrised successor to the single-digit number bitmap. It converts the value to BCD with a sequential double-dabble engine and commits all digits atomically, so a digit row never shows a half-converted number. It sits between an object's rectangle/offset generator and the drawing-priority mux, and drives `drawingRequest`/`RGBout` like every other bitmap object.

## Interface
- `DIGITS`, 4, number of decimal digits shown; digit 0 is leftmost and most significant.
- `VALUE_W`, 14, width of the binary input value.
- `DIGIT_COLOR`, 8'hFF, fixed RGB332 colour of drawn pixels.

- `clk`  in  1  pixel clock; the single clock of the block.
- `resetN`  in  1  asynchronous, active-low reset.
- `value`  in  VALUE_W  binary number to display; sampled only on an accepted `load`.
- `load`  in  1  single-cycle request to convert and display `value`.
- `busy`  out  1  high while a conversion is in progress.
- `offsetX`  in  11  pixel X offset from the object's top-left corner.
- `offsetY`  in  11  pixel Y offset from the object's top-left corner.
- `InsideRectangle`  in  1  current pixel is inside the object's bounding rectangle.
- `drawingRequest`  out  1  registered: current pixel is a lit glyph pixel.
- `RGBout`  out  8  constant `DIGIT_COLOR`.

## Operation
- FSM states and transitions:
  - IDLE -> SHIFT on `load`.
  - SHIFT -> COMMIT after `VALUE_W` iterations.
  - COMMIT -> IDLE after one cycle.
- Accepted load, in IDLE only:
  - `value` is captured.
  - If `value` > 10^DIGITS−1, the captured value is replaced by 10^DIGITS−1 (saturation, e.g. 9999 for 4 digits).
  - The BCD scratch register is cleared and the shift counter is set to `VALUE_W`.
- `load` while not in IDLE is ignored; it is neither queued nor allowed to restart.
- SHIFT, once per cycle:
  - Each BCD nibble ≥5 gets +3.
  - Then {bcd, bin} shifts left by 1 and the counter decrements.
- COMMIT: scratch BCD is copied into the displayed digit bank in one cycle.
- Render path:
  - Digit index = offsetX[10:4]; glyph column = offsetX[3:0]; glyph row = offsetY[4:0].
  - A pixel is lit when all of these hold:
    - `InsideRectangle` = 1
    - offsetX < 16·DIGITS
    - offsetY < 32
    - ROM[digit_bank[index]][row][column] = 1
- Glyph ROM:
  - Bit 15 of each row word is column 0 (leftmost).
  - BCD codes 10–15 index a blank glyph.
- Width rules:
  - BCD scratch width is 4·DIGITS.
  - The saturation constant is a localparam computed from `DIGITS`.
  - Comparisons are unsigned and widened to max(VALUE_W, needed bits).

## Timing
- Reset values:
  - State IDLE, `busy`=0, `drawingRequest`=0.
  - Digit bank all 0 (displays "0…0", or "0" with blanking).
  - `RGBout` = `DIGIT_COLOR` at all times.
- Load accepted at edge N:
  - `busy`=1 from N+1 through N+VALUE_W+1 (VALUE_W+1 cycles: SHIFT plus COMMIT).
  - New digits are visible to the render path from edge N+VALUE_W+2.
  - A new load is accepted at the first edge where `busy`=0.
- Render latency: `drawingRequest` is registered, 1 cycle after `offsetX`/`offsetY`/`InsideRectangle`.
- The render path is never stalled by conversion; the old digits display until COMMIT.
- Reset asserted mid-conversion: the FSM returns to IDLE and the partial result is discarded.

## Configuration
- `SCORE_DIGITS_LZB_EN` defined:
  - Leading-zero blanking is on.
  - Digits left of the first nonzero digit are not drawn.
  - The least significant digit is always drawn, so value 0 shows "0".
  - The blank mask is computed at COMMIT and registered alongside the digit bank.
- Not defined: all `DIGITS` digits are always drawn, including leading zeros.

## Structure
- Package `number_display_pkg`:
  - Constants `GLYPH_W`=16 and `GLYPH_H`=32.
  - `typedef logic [3:0] bcd_t`.
  - FSM state enum.
  - Constant glyph ROM `bit [0:15][0:31][0:15]` holding digits 0–9 and the blank glyph.
- Sub-module `bin2bcd_seq`:
  - Contains the FSM, saturation logic and double-dabble datapath.
  - Ports: `clk`, `resetN`, `value`, `load`, `busy`, `bcd_valid` pulse, `bcd` [4·DIGITS].
- The top level holds the digit bank, the optional blank mask and the registered pixel lookup.

## Test plan
- Reset: `resetN`=0 while probing offsetX=6, offsetY=0 -> `drawingRequest`=0 and `busy`=0; after release the digit bank is 0000.
- Conversion, with `value`=1234 and `load` pulsed:
  - `busy` is high exactly 15 cycles and the bank reads 1,2,3,4.
  - Probe offsetX=8, offsetY=0 (digit '1', column 8) -> `drawingRequest`=1 one cycle later.
  - Probe offsetX=0 -> `drawingRequest`=0.
- Saturation and ignored load:
  - `value`=12000 -> bank reads 9999.
  - `load` with 5, then `load` with 7 three cycles later -> final bank 0005 and `busy` is not extended.
- Blanking, with `value`=42 and a probe at offsetX=8, offsetY=0 ('0' glyph, lit pixel):
  - Without `SCORE_DIGITS_LZB_EN` -> `drawingRequest`=1.
  - With `SCORE_DIGITS_LZB_EN` -> 0.
  - With the macro and `value`=0, offsetX=56, offsetY=0 -> 1.
- Bounds:
  - offsetX=64 with DIGITS=4 -> 0.
  - offsetY=32 -> 0.
  - `InsideRectangle`=0 on a lit pixel -> 0.
- Reset mid-conversion: pulse `resetN` low 5 cycles after loading 1234 -> `busy`=0, the bank stays 0000, and the next load of 77 completes normally to 0077.
